canal_lock_sequencer: RTL and testbench
=======================================

// Module: canal_lock_sequencer
// PURPOSE
// Top-level sequencer for one canal lock. Latches boat arrivals at the upstream (high-water) and
// downstream (low-water) gates and arbitrates between them round-robin. Drives the water-level
// controller through its w_up/w_down commands and times the gates and lights to pass one boat at a time.
// PARAMETERS
// GATE_CYC     8    cycles for a gate to fully open or close
// ENTER_TO     200  cycles allowed for a boat to enter or exit once its gate is open (timeout)
// CNT_W        8    timer width; must satisfy 2**CNT_W > max(GATE_CYC, ENTER_TO)
// PORTS
// clk            in   1  system clock; every register is clocked on posedge
// reset          in   1  asynchronous, active-low reset
// arrive_up      in   1  pulse: boat waiting at the upstream gate
// arrive_down    in   1  pulse: boat waiting at the downstream gate
// boat_in        in   1  level: boat present inside the chamber
// water_high     in   1  from the water controller: raise complete
// water_low      in   1  from the water controller: lower complete
// w_up           out  1  1-cycle pulse: start raising the water
// w_down         out  1  1-cycle pulse: start lowering the water
// gate_up_open   out  1  level: upstream gate commanded open
// gate_down_open out  1  level: downstream gate commanded open
// light_up       out  1  green light at the upstream gate (enter/exit permitted)
// light_down     out  1  green light at the downstream gate
// busy           out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset (reset==0): state=IDLE; all outputs 0; pend_up=pend_down=0; lvl_high=0 (chamber low);
//   last_srv=DOWN. Reset applies mid-operation with no completion of the current sequence.
// - pend_x is set on arrive_x and cleared on the cycle the grant for side x is taken in IDLE.
//   An arrival for a side already pending is absorbed. An arrival on the cycle the grant for
//   that same side is taken is lost.
// - Arbitration in IDLE: one side pending -> grant it. Both pending -> grant the side != last_srv.
//   last_srv is updated on grant.
// - Notation: entry side S (UP|DOWN); other side O.
// - FSM (all transitions registered):
//   IDLE -> PREP (grant)
//   PREP: if lvl matches S (UP needs high), go to OPEN_IN. Otherwise pulse w_up/w_down for one
//     cycle, wait for water_high/water_low, toggle lvl_high, then go to OPEN_IN.
//   OPEN_IN: gate_S_open=1; wait GATE_CYC cycles -> WAIT_IN, with light_S=1.
//   WAIT_IN: boat_in==1 -> CLOSE_IN. Timer reaching ENTER_TO -> CLOSE_IN with the abort flag set.
//   CLOSE_IN: light_S=0, gate_S_open=0; wait GATE_CYC cycles. Abort set -> IDLE; else -> MOVE.
//   MOVE: pulse the water command toward side O, wait its done input, toggle lvl_high -> OPEN_OUT.
//   OPEN_OUT: gate_O_open=1, GATE_CYC cycles -> WAIT_OUT with light_O=1. WAIT_OUT: boat_in==0 or
//     ENTER_TO elapsed -> CLOSE_OUT. CLOSE_OUT: close gate O, GATE_CYC cycles -> IDLE.
// - Water done inputs: sampled only in PREP/MOVE after the pulse; ignored in all other states.
//   A done input already high in the same cycle as the pulse is ignored; only later cycles count.
// - Both gates are never commanded open simultaneously (safety invariant).
// - The water command is only issued with both gates closed.
// - Timer: CNT_W-bit counter, cleared on every state change, saturates at all-ones (no wrap).
// - w_up and w_down are never asserted together; each pulses exactly once per water move.
// STRUCTURE
// - canal_pkg: typedef enum {IDLE, PREP, OPEN_IN, WAIT_IN, CLOSE_IN, MOVE, OPEN_OUT, WAIT_OUT,
//   CLOSE_OUT} lock_state_t; typedef enum logic {DOWN, UP} side_t.
// - One sub-module, lock_timer: count/clear/saturate with done compares against GATE_CYC and ENTER_TO.
//   The FSM, arbiter and pending latches stay in this module.
// TESTING
// 1. Reset low, then arrive_down; boat_in rises after gate open -> no w_ pulse in PREP;
//    gate_down_open for 8+ cycles; after close, one w_up pulse; water_high -> gate_up_open;
//    boat_in=0 -> IDLE, busy=0.
// 2. arrive_up with lvl low -> w_up pulse in PREP; wait water_high; then upstream entry;
//    MOVE issues exactly one w_down.
// 3. arrive_up and arrive_down in the same cycle after reset -> UP granted first (last_srv=DOWN),
//    DOWN served next without a new arrival.
// 4. No boat_in for 200 cycles in WAIT_IN -> gate closes, no MOVE pulse, IDLE, lvl unchanged.
// 5. reset low during MOVE -> all outputs 0 next cycle, pending cleared, lvl_high=0.
// 6. Assertions through all runs: never gate_up_open&&gate_down_open;
//    never w_up&&w_down; w_* only while both gates are closed.

Source files
------------

// File: rtl/canal_pkg.sv
// Shared types for the canal lock sequencer: FSM states and gate side.
package canal_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PREP,
        OPEN_IN,
        WAIT_IN,
        CLOSE_IN,
        MOVE,
        OPEN_OUT,
        WAIT_OUT,
        CLOSE_OUT
    } lock_state_t;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } side_t;

    // The gate facing the entry gate across the chamber.
    function automatic side_t other_side(input side_t s);
        return (s == UP) ? DOWN : UP;
    endfunction

endpackage

// File: rtl/canal_lock_sequencer_timer.sv
// Per-state cycle timer: cleared on every state change, saturates instead of wrapping.
// Done flags rise once the current state has lasted GATE_CYC or ENTER_TO cycles.
module lock_timer #(
    parameter int GATE_CYC = 8,
    parameter int ENTER_TO = 200,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic gate_done,
    output logic enter_done
);

    logic [CNT_W-1:0] cnt;

    // Count cycles spent in the current state; hold at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt is 0 on the first cycle of a state, so N cycles have elapsed when cnt reaches N-1.
    assign gate_done  = (cnt >= CNT_W'(GATE_CYC - 1));
    assign enter_done = (cnt >= CNT_W'(ENTER_TO - 1));

endmodule

// File: rtl/canal_lock_sequencer.sv
// Canal lock sequencer: latches boat arrivals at both gates, arbitrates round-robin,
// commands the water-level controller and sequences gates and lights for one boat at a time.
module canal_lock_sequencer
    import canal_pkg::*;
#(
    parameter int GATE_CYC = 8,
    parameter int ENTER_TO = 200,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic arrive_up,
    input  logic arrive_down,
    input  logic boat_in,
    input  logic water_high,
    input  logic water_low,
    output logic w_up,
    output logic w_down,
    output logic gate_up_open,
    output logic gate_down_open,
    output logic light_up,
    output logic light_down,
    output logic busy
);

    lock_state_t state, state_nxt;
    side_t       side, side_nxt;           // entry side of the boat being served
    side_t       last_srv, last_srv_nxt;
    logic        lvl_high, lvl_high_nxt;   // believed chamber water level
    logic        pend_up, pend_up_nxt;
    logic        pend_down, pend_down_nxt;
    logic        abort, abort_nxt;         // entry timed out, skip the crossing
    logic        wsent, wsent_nxt;         // water command already pulsed in this state
    logic        timer_clear;
    logic        gate_done, enter_done;
    logic        need_high;
    side_t       oside;

    assign need_high = (side == UP);
    assign oside     = other_side(side);

    lock_timer #(
        .GATE_CYC (GATE_CYC),
        .ENTER_TO (ENTER_TO),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (timer_clear),
        .gate_done  (gate_done),
        .enter_done (enter_done)
    );

    // State and bookkeeping registers; reset abandons any sequence in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            side      <= DOWN;
            last_srv  <= DOWN;
            lvl_high  <= 1'b0;
            pend_up   <= 1'b0;
            pend_down <= 1'b0;
            abort     <= 1'b0;
            wsent     <= 1'b0;
        end else begin
            state     <= state_nxt;
            side      <= side_nxt;
            last_srv  <= last_srv_nxt;
            lvl_high  <= lvl_high_nxt;
            pend_up   <= pend_up_nxt;
            pend_down <= pend_down_nxt;
            abort     <= abort_nxt;
            wsent     <= wsent_nxt;
        end
    end

    // Next-state, arbitration and output decode.
    always_comb begin
        state_nxt      = state;
        side_nxt       = side;
        last_srv_nxt   = last_srv;
        lvl_high_nxt   = lvl_high;
        pend_up_nxt    = pend_up | arrive_up;
        pend_down_nxt  = pend_down | arrive_down;
        abort_nxt      = abort;
        wsent_nxt      = wsent;
        w_up           = 1'b0;
        w_down         = 1'b0;
        gate_up_open   = 1'b0;
        gate_down_open = 1'b0;
        light_up       = 1'b0;
        light_down     = 1'b0;
        busy           = (state != IDLE);

        case (state)
            IDLE: begin
                // An arrival on the granting cycle for the same side is dropped with the clear.
                if (pend_up && (!pend_down || last_srv == DOWN)) begin
                    side_nxt     = UP;
                    last_srv_nxt = UP;
                    pend_up_nxt  = 1'b0;
                    abort_nxt    = 1'b0;
                    state_nxt    = PREP;
                end else if (pend_down) begin
                    side_nxt      = DOWN;
                    last_srv_nxt  = DOWN;
                    pend_down_nxt = 1'b0;
                    abort_nxt     = 1'b0;
                    state_nxt     = PREP;
                end
            end
            PREP: begin
                if (lvl_high == need_high) begin
                    state_nxt = OPEN_IN;
                end else if (!wsent) begin
                    w_up      = need_high;
                    w_down    = !need_high;
                    wsent_nxt = 1'b1;
                end else if (need_high ? water_high : water_low) begin
                    lvl_high_nxt = !lvl_high;
                    state_nxt    = OPEN_IN;
                end
            end
            OPEN_IN: begin
                gate_up_open   = (side == UP);
                gate_down_open = (side == DOWN);
                if (gate_done) state_nxt = WAIT_IN;
            end
            WAIT_IN: begin
                gate_up_open   = (side == UP);
                gate_down_open = (side == DOWN);
                light_up       = (side == UP);
                light_down     = (side == DOWN);
                if (boat_in) begin
                    state_nxt = CLOSE_IN;
                end else if (enter_done) begin
                    abort_nxt = 1'b1;
                    state_nxt = CLOSE_IN;
                end
            end
            CLOSE_IN: begin
                if (gate_done) state_nxt = abort ? IDLE : MOVE;
            end
            MOVE: begin
                if (!wsent) begin
                    w_up      = (oside == UP);
                    w_down    = (oside == DOWN);
                    wsent_nxt = 1'b1;
                end else if ((oside == UP) ? water_high : water_low) begin
                    lvl_high_nxt = !lvl_high;
                    state_nxt    = OPEN_OUT;
                end
            end
            OPEN_OUT: begin
                gate_up_open   = (oside == UP);
                gate_down_open = (oside == DOWN);
                if (gate_done) state_nxt = WAIT_OUT;
            end
            WAIT_OUT: begin
                gate_up_open   = (oside == UP);
                gate_down_open = (oside == DOWN);
                light_up       = (oside == UP);
                light_down     = (oside == DOWN);
                if (!boat_in || enter_done) state_nxt = CLOSE_OUT;
            end
            CLOSE_OUT: begin
                if (gate_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Every state change restarts the timer and re-arms the water command.
        timer_clear = (state_nxt != state);
        if (timer_clear) wsent_nxt = 1'b0;
    end

endmodule

// File: tb/tb_canal_lock_sequencer.sv
// Scoreboard bench for canal_lock_sequencer: expected output events are queued per scenario
// and compared in order as the monitor sees them, with timing and safety checks alongside.
module tb_canal_lock_sequencer;

    localparam int GATE_CYC = 8;
    localparam int ENTER_TO = 200;
    localparam int WDELAY   = 3;

    localparam int EV_WUP  = 1;
    localparam int EV_WDN  = 2;
    localparam int EV_GUP  = 3;
    localparam int EV_GDN  = 4;
    localparam int EV_IDLE = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic arrive_up = 1'b0;
    logic arrive_down = 1'b0;
    logic boat_in = 1'b0;
    logic water_high = 1'b0;
    logic water_low = 1'b0;
    logic w_up, w_down, gate_up_open, gate_down_open, light_up, light_down, busy;

    int checks = 0;
    int errors = 0;
    int evq[$];
    int cyc = 0;
    int exp_light_len = -1;

    canal_lock_sequencer #(
        .GATE_CYC (GATE_CYC),
        .ENTER_TO (ENTER_TO),
        .CNT_W    (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .arrive_up      (arrive_up),
        .arrive_down    (arrive_down),
        .boat_in        (boat_in),
        .water_high     (water_high),
        .water_low      (water_low),
        .w_up           (w_up),
        .w_down         (w_down),
        .gate_up_open   (gate_up_open),
        .gate_down_open (gate_down_open),
        .light_up       (light_up),
        .light_down     (light_down),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mon_event(input int code);
        if (evq.size() == 0) check_val("ev_unexpected", code, 0);
        else                 check_val("ev_order", code, evq.pop_front());
    endtask

    // Water controller: done flags sit stale-high after reset; a command clears them the
    // cycle after the pulse and raises the target flag WDELAY cycles later.
    int  wage = -1;
    bit  wtarget = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            wage = -1;
            water_high = 1'b1;
            water_low = 1'b1;
        end else if (w_up || w_down) begin
            wage = 0;
            wtarget = w_up;
        end else if (wage >= 0) begin
            wage++;
            if (wage == 1) begin
                water_high = 1'b0;
                water_low = 1'b0;
            end
            if (wage == 1 + WDELAY) begin
                if (wtarget) water_high = 1'b1;
                else         water_low = 1'b1;
                wage = -1;
            end
        end
    end

    // Monitor: event stream, gate/light timing and safety invariants.
    logic p_gu = 0, p_gd = 0, p_lu = 0, p_ld = 0, p_busy = 0;
    int pulse_cyc = -1, grise_cyc = -1, gfall_cyc = -1, lrise_cyc = -1;
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            p_gu = 0; p_gd = 0; p_lu = 0; p_ld = 0; p_busy = 0;
            pulse_cyc = -1; grise_cyc = -1; gfall_cyc = -1; lrise_cyc = -1;
        end else begin
            check_val("gates_excl", int'(gate_up_open && gate_down_open), 0);
            check_val("w_excl", int'(w_up && w_down), 0);
            check_val("w_gates", int'((w_up || w_down) && (gate_up_open || gate_down_open)), 0);
            if (w_up)   mon_event(EV_WUP);
            if (w_down) mon_event(EV_WDN);
            if (w_up || w_down) begin
                if (gfall_cyc >= 0) check_val("close_len", cyc - gfall_cyc, GATE_CYC);
                gfall_cyc = -1;
                pulse_cyc = cyc;
            end
            if ((gate_up_open && !p_gu) || (gate_down_open && !p_gd)) begin
                mon_event(gate_up_open ? EV_GUP : EV_GDN);
                if (pulse_cyc >= 0) check_val("water_delay", cyc - pulse_cyc, WDELAY + 2);
                pulse_cyc = -1;
                grise_cyc = cyc;
            end
            if ((!gate_up_open && p_gu) || (!gate_down_open && p_gd)) gfall_cyc = cyc;
            if ((light_up && !p_lu) || (light_down && !p_ld)) begin
                check_val("open_len", cyc - grise_cyc, GATE_CYC);
                lrise_cyc = cyc;
            end
            if (((!light_up && p_lu) || (!light_down && p_ld)) && exp_light_len >= 0)
                check_val("light_len", cyc - lrise_cyc, exp_light_len);
            if (!busy && p_busy) begin
                mon_event(EV_IDLE);
                if (gfall_cyc >= 0) check_val("close_len", cyc - gfall_cyc, GATE_CYC);
                gfall_cyc = -1;
            end
            p_gu = gate_up_open; p_gd = gate_down_open;
            p_lu = light_up; p_ld = light_down; p_busy = busy;
        end
    end

    function automatic bit cond(input int w);
        case (w)
            0:       return light_up;
            1:       return light_down;
            2:       return !busy;
            default: return w_up;
        endcase
    endfunction

    task automatic wait_for(input int w, input int budget, input string tag);
        int n = 0;
        while (!cond(w) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, int'(cond(w)), 1);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_w_up"}, int'(w_up), 0);
        check_val({tag, "_w_down"}, int'(w_down), 0);
        check_val({tag, "_gate_up"}, int'(gate_up_open), 0);
        check_val({tag, "_gate_down"}, int'(gate_down_open), 0);
        check_val({tag, "_light_up"}, int'(light_up), 0);
        check_val({tag, "_light_down"}, int'(light_down), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_arrive(input bit up, input bit dn);
        arrive_up = up;
        arrive_down = dn;
        @(negedge clk);
        arrive_up = 1'b0;
        arrive_down = 1'b0;
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        evq.push_back(a); evq.push_back(b); evq.push_back(c); evq.push_back(d);
    endtask

    // One full passage: boat enters from the given side and leaves at the other.
    task automatic serve(input bit up);
        wait_for(up ? 0 : 1, 400, "enter_light");
        repeat (2) @(negedge clk);
        boat_in = 1'b1;
        wait_for(up ? 1 : 0, 400, "exit_light");
        repeat (2) @(negedge clk);
        boat_in = 1'b0;
        wait_for(2, 100, "idle");
    endtask

    task automatic end_test(input string tag);
        repeat (2) @(negedge clk);
        check_val({tag, "_evq_left"}, evq.size(), 0);
        evq.delete();
    endtask

    initial begin
        #2 reset = 1'b0;
        @(negedge clk);
        do_reset();

        // Downstream boat with chamber low: no prep pulse, raise in MOVE.
        push4(EV_GDN, EV_WUP, EV_GUP, EV_IDLE);
        pulse_arrive(1'b0, 1'b1);
        serve(1'b0);
        end_test("t1");

        // Upstream boat with chamber low: raise in PREP, lower in MOVE.
        do_reset();
        push4(EV_WUP, EV_GUP, EV_WDN, EV_GDN);
        evq.push_back(EV_IDLE);
        pulse_arrive(1'b1, 1'b0);
        serve(1'b1);
        end_test("t2");

        // Simultaneous arrivals: UP first, then DOWN without a new arrival.
        do_reset();
        push4(EV_WUP, EV_GUP, EV_WDN, EV_GDN);
        evq.push_back(EV_IDLE);
        push4(EV_GDN, EV_WUP, EV_GUP, EV_IDLE);
        pulse_arrive(1'b1, 1'b1);
        serve(1'b1);
        serve(1'b0);
        end_test("t3");

        // Entry timeout with chamber high: lower, open, abort without a MOVE pulse.
        push4(EV_WDN, EV_GDN, EV_IDLE, 0);
        void'(evq.pop_back());
        exp_light_len = ENTER_TO;
        pulse_arrive(1'b0, 1'b1);
        wait_for(1, 400, "t4_light");
        wait_for(2, ENTER_TO + 50, "t4_idle");
        exp_light_len = -1;
        end_test("t4");

        // Level stayed low; duplicate UP arrivals while busy collapse into one service.
        push4(EV_GDN, EV_WUP, EV_GUP, EV_IDLE);
        push4(EV_GUP, EV_WDN, EV_GDN, EV_IDLE);
        pulse_arrive(1'b0, 1'b1);
        wait_for(1, 400, "t4b_light");
        pulse_arrive(1'b1, 1'b0);
        pulse_arrive(1'b1, 1'b0);
        boat_in = 1'b1;
        wait_for(0, 400, "t4b_exit");
        repeat (2) @(negedge clk);
        boat_in = 1'b0;
        wait_for(2, 100, "t4b_idle");
        serve(1'b1);
        repeat (20) @(negedge clk);
        check_val("t4b_no_extra", int'(busy), 0);
        end_test("t4b");

        // Reset during MOVE with an UP arrival pending.
        do_reset();
        evq.push_back(EV_GDN);
        evq.push_back(EV_WUP);
        pulse_arrive(1'b0, 1'b1);
        wait_for(1, 400, "t5_light");
        repeat (2) @(negedge clk);
        boat_in = 1'b1;
        wait_for(3, 200, "t5_move");
        arrive_up = 1'b1;
        @(negedge clk);
        arrive_up = 1'b0;
        check_val("t5_evq_left", evq.size(), 0);
        reset = 1'b0;
        boat_in = 1'b0;
        #1;
        check_zero("t5_rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_val("t5_pend_clr", int'(busy), 0);
        push4(EV_GDN, EV_WUP, EV_GUP, EV_IDLE);
        pulse_arrive(1'b0, 1'b1);
        serve(1'b0);
        end_test("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
